// File: rtl/regfile_sb.sv
// Register file with a per-register pending (scoreboard) bit, a pending counter and a WAW issue stall.
// Optional same-cycle write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module regfile_sb #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic [AW-1:0]   radd1,
  input  logic [AW-1:0]   radd2,
  output logic [XLEN-1:0] rs1,
  output logic [XLEN-1:0] rs2,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            iss_en,
  input  logic [AW-1:0]   iss_add,
  input  logic            wen,
  input  logic [AW-1:0]   wadd,
  input  logic [XLEN-1:0] wdata,
  output logic [AW:0]     pend_cnt,
  output logic            iss_stall
);

  localparam int            IW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW:0]   NREG_W = (AW+1)'(NREG);

  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] pend_q;
  logic [NREG-1:0] pend_d;
  logic [AW:0]     cnt_q;
  logic [AW:0]     cnt_d;
  logic            wr_ok_s;
  logic            iss_ok_s;
  logic            inc_s;
  logic            dec_s;

  // An address is usable only inside the array and, with ZERO_REG, not register 0.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return ({1'b0, a} < NREG_W) && ((ZERO_REG == 0) || (a != '0));
  endfunction

  function automatic logic [IW-1:0] idx(input logic [AW-1:0] a);
    return a[IW-1:0];
  endfunction

  assign wr_ok_s   = wen & addr_ok(wadd);
  assign iss_ok_s  = iss_en & addr_ok(iss_add);
  assign iss_stall = iss_ok_s & pend_q[idx(iss_add)];
  assign pend_cnt  = cnt_q;

  // Next pending vector and counter delta; an issue applied after the clear lets the new producer win.
  always_comb begin
    pend_d = pend_q;
    inc_s  = 1'b0;
    dec_s  = 1'b0;
    if (wr_ok_s) begin
      pend_d[idx(wadd)] = 1'b0;
      dec_s = pend_q[idx(wadd)] & ~(iss_ok_s && (iss_add == wadd));
    end else begin
      dec_s = 1'b0;
    end
    if (iss_ok_s) begin
      pend_d[idx(iss_add)] = 1'b1;
      inc_s = ~pend_q[idx(iss_add)];
    end else begin
      inc_s = 1'b0;
    end
    cnt_d = cnt_q + {{AW{1'b0}}, inc_s} - {{AW{1'b0}}, dec_s};
  end

  // Pending state and counter; reset clears them immediately.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  // Register array writeback.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_ok_s && (idx(wadd) == IW'(i))) regs_q[i] <= wdata;
      end
    end
  end

  // Combinational read ports; unusable addresses read zero and never busy.
  always_comb begin
    rs1      = '0;
    rs1_busy = 1'b0;
    rs2      = '0;
    rs2_busy = 1'b0;
    if (addr_ok(radd1)) begin
      rs1      = regs_q[idx(radd1)];
      rs1_busy = pend_q[idx(radd1)];
    end else begin
      rs1      = '0;
      rs1_busy = 1'b0;
    end
    if (addr_ok(radd2)) begin
      rs2      = regs_q[idx(radd2)];
      rs2_busy = pend_q[idx(radd2)];
    end else begin
      rs2      = '0;
      rs2_busy = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_ok_s && (radd1 == wadd)) begin
      rs1      = wdata;
      rs1_busy = 1'b0;
    end else begin
      rs1_busy = rs1_busy;
    end
    if (wr_ok_s && (radd2 == wadd)) begin
      rs2      = wdata;
      rs2_busy = 1'b0;
    end else begin
      rs2_busy = rs2_busy;
    end
`else
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: directed stimulus queues expectations, a monitor compares at negedge.
module tb_regfile_sb;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        nrst24 = 1'b0;
  logic [4:0]  radd1 = '0, radd2 = '0, iss_add = '0, wadd = '0;
  logic        iss_en = 1'b0, wen = 1'b0;
  logic [31:0] wdata = '0;

  logic [31:0] rs1_m, rs2_m, rs1_n, rs2_n;
  logic        b1_m, b2_m, b1_n, b2_n, st_m, st_n;
  logic [5:0]  cnt_m, cnt_n;

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .nrst(nrst), .radd1(radd1), .radd2(radd2),
    .rs1(rs1_m), .rs2(rs2_m), .rs1_busy(b1_m), .rs2_busy(b2_m),
    .iss_en(iss_en), .iss_add(iss_add), .wen(wen), .wadd(wadd), .wdata(wdata),
    .pend_cnt(cnt_m), .iss_stall(st_m)
  );

  regfile_sb #(.NREG(24)) dut24 (
    .clk(clk), .nrst(nrst24), .radd1(radd1), .radd2(radd2),
    .rs1(rs1_n), .rs2(rs2_n), .rs1_busy(b1_n), .rs2_busy(b2_n),
    .iss_en(iss_en), .iss_add(iss_add), .wen(wen), .wadd(wadd), .wdata(wdata),
    .pend_cnt(cnt_n), .iss_stall(st_n)
  );

  typedef struct {
    string       nm;
    bit          sel;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        b1;
    logic        b2;
    logic        st;
    logic [5:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] a1, a2;
      logic        ab1, ab2, ast;
      logic [5:0]  ac;
      e   = exp_q.pop_front();
      a1  = e.sel ? rs1_n : rs1_m;
      a2  = e.sel ? rs2_n : rs2_m;
      ab1 = e.sel ? b1_n : b1_m;
      ab2 = e.sel ? b2_n : b2_m;
      ast = e.sel ? st_n : st_m;
      ac  = e.sel ? cnt_n : cnt_m;
      checks++;
      if (a1 !== e.rs1 || a2 !== e.rs2 || ab1 !== e.b1 || ab2 !== e.b2 ||
          ast !== e.st || ac !== e.cnt) begin
        errors++;
        $display("FAIL %s: got rs1=%h rs2=%h b1=%b b2=%b stall=%b cnt=%0d, expected rs1=%h rs2=%h b1=%b b2=%b stall=%b cnt=%0d",
                 e.nm, a1, a2, ab1, ab2, ast, ac, e.rs1, e.rs2, e.b1, e.b2, e.st, e.cnt);
      end
    end
  end

  task automatic step(input string nm, input bit sel, input logic rst_v,
                      input logic ie, input logic [4:0] ia,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd,
                      input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic eb1, input logic eb2, input logic est, input logic [5:0] ec);
    exp_t e;
    @(posedge clk);
    #1;
    nrst = rst_v; iss_en = ie; iss_add = ia; wen = we; wadd = wa; wdata = wd;
    radd1 = r1; radd2 = r2;
    e.nm = nm; e.sel = sel; e.rs1 = e1; e.rs2 = e2; e.b1 = eb1; e.b2 = eb2;
    e.st = est; e.cnt = ec;
    exp_q.push_back(e);
  endtask

  initial begin
    //    name          sel rst ie ia     we wa     wdata          r1     r2     rs1            rs2            b1    b2    st    cnt
    step("rst_hold",   0, 0, 0, 5'd0,  1, 5'd5,  32'h1111_1111, 5'd5,  5'd31, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    for (int a = 0; a < 32; a++)
      step("rd_all",   0, 1, 0, 5'd0,  0, 5'd0,  32'h0, 5'(a), 5'(31 - a),   32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("wr5",        0, 1, 0, 5'd0,  1, 5'd5,  32'hDEADBEEF, 5'd5,  5'd0,  BYP ? 32'hDEADBEEF : 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 6'd0);
    step("rd5_wr0",    0, 1, 0, 5'd0,  1, 5'd0,  32'hDEADBEEF, 5'd5,  5'd0,  32'hDEADBEEF,  32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("rd0",        0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd0,  5'd5,  32'h0,         32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 6'd0);
    step("iss7",       0, 1, 1, 5'd7,  0, 5'd0,  32'h0,        5'd7,  5'd5,  32'h0,         32'hDEADBEEF,  1'b0, 1'b0, 1'b0, 6'd0);
    step("busy7",      0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd1);
    step("wb7",        0, 1, 0, 5'd0,  1, 5'd7,  32'h12,       5'd7,  5'd5,  BYP ? 32'h12 : 32'h0, 32'hDEADBEEF, ~BYP, 1'b0, 1'b0, 6'd1);
    step("after7",     0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd7,  5'd0,  32'h12,        32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("iss3",       0, 1, 1, 5'd3,  0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("same3",      0, 1, 1, 5'd3,  1, 5'd3,  32'h33,       5'd3,  5'd0,  BYP ? 32'h33 : 32'h0, 32'h0, ~BYP, 1'b0, 1'b1, 6'd1);
    step("stall3",     0, 1, 1, 5'd3,  0, 5'd0,  32'h0,        5'd3,  5'd0,  32'h33,        32'h0,         1'b1, 1'b0, 1'b1, 6'd1);
    step("diff",       0, 1, 1, 5'd9,  1, 5'd3,  32'h44,       5'd9,  5'd3,  32'h0, BYP ? 32'h44 : 32'h33, 1'b0, ~BYP, 1'b0, 6'd1);
    step("diff_after", 0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd9,  5'd3,  32'h0,         32'h44,        1'b1, 1'b0, 1'b0, 6'd1);
    step("wr_nonpend", 0, 1, 0, 5'd0,  1, 5'd5,  32'h55,       5'd9,  5'd5,  32'h0, BYP ? 32'h55 : 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, 6'd1);
    step("iss1",       0, 1, 1, 5'd1,  0, 5'd0,  32'h0,        5'd5,  5'd9,  32'h55,        32'h0,         1'b0, 1'b1, 1'b0, 6'd1);
    step("iss2",       0, 1, 1, 5'd2,  0, 5'd0,  32'h0,        5'd1,  5'd2,  32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd2);
    step("iss4",       0, 1, 1, 5'd4,  0, 5'd0,  32'h0,        5'd2,  5'd4,  32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 6'd3);
    step("pre_rst",    0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd4,  5'd5,  32'h0,         32'h55,        1'b1, 1'b0, 1'b0, 6'd4);
    step("mid_rst",    0, 0, 1, 5'd4,  0, 5'd0,  32'h0,        5'd4,  5'd5,  32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("post_rst",   0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd4,  5'd1,  32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("zero_iw",    0, 1, 1, 5'd0,  1, 5'd0,  32'h99,       5'd0,  5'd5,  32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("zero_after", 0, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd0,  5'd0,  32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    nrst24 = 1'b1;
    step("n24_wi30",   1, 1, 1, 5'd30, 1, 5'd30, 32'hAAAA,     5'd30, 5'd23, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("n24_iss23",  1, 1, 1, 5'd23, 0, 5'd0,  32'h0,        5'd30, 5'd23, 32'h0,         32'h0,         1'b0, 1'b0, 1'b0, 6'd0);
    step("n24_iss30",  1, 1, 1, 5'd30, 1, 5'd30, 32'hBB,       5'd30, 5'd23, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 6'd1);
    step("n24_end",    1, 1, 0, 5'd0,  0, 5'd0,  32'h0,        5'd30, 5'd23, 32'h0,         32'h0,         1'b0, 1'b1, 1'b0, 6'd1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
